// File: rtl/wb_slave_arbiter.sv
// Two-master Wishbone arbiter sharing one WB4 slave: round-robin grant, bus lock
// for the owner's CYC, and a watchdog that terminates slave cycles never ACKed.
module wb_slave_arbiter #(
  parameter int unsigned    TIMEOUT = 16,
  parameter int unsigned    AW      = 32,
  parameter int unsigned    DW      = 32,
  parameter logic [DW-1:0]  TO_DATA = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  // master 0 (core)
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat_o,
  output logic [DW-1:0] m0_dat_i,
  output logic          m0_ack,
  // master 1 (debug/DMA)
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat_o,
  output logic [DW-1:0] m1_dat_i,
  output logic          m1_ack,
  // shared slave
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack,
  // observability
  output logic [1:0]    gnt,
  output logic          timeout
);

  localparam int unsigned   CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] WD_ONE  = CW'(1);
  localparam logic [CW-1:0] WD_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e          state_r;
  state_e          state_nxt_s;
  logic            last_r;
  logic            last_nxt_s;
  logic [CW-1:0]   wd_cnt_r;
  logic [CW-1:0]   wd_cnt_nxt_s;
  logic [1:0]      gnt_r;

  logic            own_cyc_s;
  logic            own_stb_s;
  logic            own_we_s;
  logic [AW-1:0]   own_adr_s;
  logic [DW-1:0]   own_dat_s;
  logic            wd_hit_s;

  function automatic logic [1:0] state_to_gnt(input state_e st);
    logic [1:0] g;
    case (st)
      OWN0:    g = 2'b01;
      OWN1:    g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

  // Select the owning master's request signals; nothing when idle.
  always_comb begin
    own_cyc_s = 1'b0;
    own_stb_s = 1'b0;
    own_we_s  = 1'b0;
    own_adr_s = {AW{1'b0}};
    own_dat_s = {DW{1'b0}};
    case (state_r)
      OWN0: begin
        own_cyc_s = m0_cyc;
        own_stb_s = m0_stb;
        own_we_s  = m0_we;
        own_adr_s = m0_adr;
        own_dat_s = m0_dat_o;
      end
      OWN1: begin
        own_cyc_s = m1_cyc;
        own_stb_s = m1_stb;
        own_we_s  = m1_we;
        own_adr_s = m1_adr;
        own_dat_s = m1_dat_o;
      end
      default: begin
        own_cyc_s = 1'b0;
        own_stb_s = 1'b0;
      end
    endcase
  end

  // A genuine ACK in the last allowed cycle wins over the watchdog.
  assign wd_hit_s = own_cyc_s & own_stb_s & ~s_ack & (wd_cnt_r == WD_LAST);

  // Next-state logic: round-robin on contention, release only when CYC drops.
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    case (state_r)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          if (last_r) begin
            state_nxt_s = OWN0;
            last_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = OWN1;
            last_nxt_s  = 1'b1;
          end
        end else if (m0_cyc) begin
          state_nxt_s = OWN0;
          last_nxt_s  = 1'b0;
        end else if (m1_cyc) begin
          state_nxt_s = OWN1;
          last_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OWN0: begin
        if (!m0_cyc) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OWN0;
        end
      end
      OWN1: begin
        if (!m1_cyc) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OWN1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Watchdog counts unacknowledged strobe cycles and saturates instead of wrapping.
  always_comb begin
    wd_cnt_nxt_s = wd_cnt_r;
    if (!own_cyc_s || !own_stb_s || s_ack || wd_hit_s || (state_nxt_s != state_r)) begin
      wd_cnt_nxt_s = WD_ZERO;
    end else if (wd_cnt_r != WD_MAX) begin
      wd_cnt_nxt_s = wd_cnt_r + WD_ONE;
    end else begin
      wd_cnt_nxt_s = wd_cnt_r;
    end
  end

  // State, fairness pointer, watchdog and grant registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      last_r   <= 1'b1;
      wd_cnt_r <= WD_ZERO;
      gnt_r    <= 2'b00;
    end else begin
      state_r  <= state_nxt_s;
      last_r   <= last_nxt_s;
      wd_cnt_r <= wd_cnt_nxt_s;
      gnt_r    <= state_to_gnt(state_nxt_s);
    end
  end

  // Slave side follows the owner, except the abort cycle drops STB/CYC so writes are lost.
  always_comb begin
    s_cyc   = own_cyc_s & ~wd_hit_s;
    s_stb   = own_stb_s & ~wd_hit_s;
    s_we    = own_we_s;
    s_adr   = own_adr_s;
    s_dat_o = own_dat_s;
  end

  // Return path: only the owner sees ACK/data; the other master stays stalled.
  always_comb begin
    m0_ack   = 1'b0;
    m0_dat_i = {DW{1'b0}};
    m1_ack   = 1'b0;
    m1_dat_i = {DW{1'b0}};
    case (state_r)
      OWN0: begin
        m0_ack   = s_ack | wd_hit_s;
        m0_dat_i = wd_hit_s ? TO_DATA : s_dat_i;
      end
      OWN1: begin
        m1_ack   = s_ack | wd_hit_s;
        m1_dat_i = wd_hit_s ? TO_DATA : s_dat_i;
      end
      default: begin
        m0_ack = 1'b0;
        m1_ack = 1'b0;
      end
    endcase
  end

  assign gnt     = gnt_r;
  assign timeout = wd_hit_s;

endmodule

// File: tb/tb_wb_slave_arbiter.sv
// Directed bench for wb_slave_arbiter: arbitration latency, round-robin, bus lock,
// stalled non-owner, watchdog timeout / last-cycle ACK, and asynchronous reset.
module tb_wb_slave_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat_o, m0_dat_i;
  logic        m0_ack;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat_o, m1_dat_i;
  logic        m1_ack;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic        s_ack;
  logic [1:0]  gnt;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;

  wb_slave_arbiter #(.TIMEOUT(16), .TO_DATA(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_o(m0_dat_o), .m0_dat_i(m0_dat_i), .m0_ack(m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_o(m1_dat_o), .m1_dat_i(m1_dat_i), .m1_ack(m1_ack),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack),
    .gnt(gnt), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic at_ne();
    @(negedge clk);
  endtask

  task automatic set_m0(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
    m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat_o = dat;
  endtask

  task automatic set_m1(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
    m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat_o = dat;
  endtask

  initial begin
    rst = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_ack = 1'b0;
    s_dat_i = 32'h0;

    // reset values
    at_ne();
    chk("rst_gnt", gnt, 32'd0);
    chk("rst_timeout", timeout, 32'd0);
    chk("rst_s_stb", s_stb, 32'd0);
    chk("rst_s_cyc", s_cyc, 32'd0);
    chk("rst_s_we", s_we, 32'd0);
    chk("rst_m0_ack", m0_ack, 32'd0);
    chk("rst_m0_dat", m0_dat_i, 32'd0);
    chk("rst_m1_ack", m1_ack, 32'd0);
    chk("rst_m1_dat", m1_dat_i, 32'd0);
    rst = 1'b1;
    adv();

    // single m0 write
    set_m0(1'b1, 1'b1, 1'b1, 32'h0, 32'h1234_5678);
    at_ne();
    chk("t1_lat_stb", s_stb, 32'd0);
    chk("t1_lat_gnt", gnt, 32'd0);
    adv();
    at_ne();
    chk("t1_gnt", gnt, 32'd1);
    chk("t1_s_stb", s_stb, 32'd1);
    chk("t1_s_cyc", s_cyc, 32'd1);
    chk("t1_s_we", s_we, 32'd1);
    chk("t1_s_adr", s_adr, 32'h0);
    chk("t1_s_dat", s_dat_o, 32'h1234_5678);
    chk("t1_no_ack_yet", m0_ack, 32'd0);
    adv();
    s_ack = 1'b1;
    at_ne();
    chk("t1_m0_ack", m0_ack, 32'd1);
    chk("t1_m1_ack", m1_ack, 32'd0);
    adv();
    s_ack = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    at_ne();
    chk("t1_ack_once", m0_ack, 32'd0);
    chk("t1_s_cyc_drop", s_cyc, 32'd0);
    chk("t1_gnt_hold", gnt, 32'd1);
    adv();
    at_ne();
    chk("t1_gnt_idle", gnt, 32'd0);

    // fresh reset, then simultaneous contention
    rst = 1'b0;
    adv();
    at_ne();
    rst = 1'b1;
    adv();
    set_m0(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    set_m1(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    at_ne();
    chk("t2_idle", gnt, 32'd0);
    adv();
    s_ack = 1'b1;
    s_dat_i = 32'hAAAA_0001;
    at_ne();
    chk("t2_first_m0", gnt, 32'd1);
    chk("t2_s_adr0", s_adr, 32'h10);
    chk("t2_m0_ack", m0_ack, 32'd1);
    chk("t2_m0_dat", m0_dat_i, 32'hAAAA_0001);
    chk("t2_m1_stall_ack", m1_ack, 32'd0);
    chk("t2_m1_stall_dat", m1_dat_i, 32'd0);
    adv();
    s_ack = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    at_ne();
    chk("t2_rel_gnt", gnt, 32'd1);
    adv();
    at_ne();
    chk("t2_gap_gnt", gnt, 32'd0);
    chk("t2_gap_stb", s_stb, 32'd0);
    adv();
    s_ack = 1'b1;
    s_dat_i = 32'hBBBB_0002;
    at_ne();
    chk("t2_second_m1", gnt, 32'd2);
    chk("t2_s_adr1", s_adr, 32'h20);
    chk("t2_m1_ack", m1_ack, 32'd1);
    chk("t2_m1_dat", m1_dat_i, 32'hBBBB_0002);
    chk("t2_m0_no_ack", m0_ack, 32'd0);
    adv();
    s_ack = 1'b0;
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m0(1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
    at_ne();
    chk("t2_m1_rel_gnt", gnt, 32'd2);
    chk("t2_m0_wait_ack", m0_ack, 32'd0);
    adv();
    set_m1(1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
    at_ne();
    chk("t2_gap2_gnt", gnt, 32'd0);
    adv();
    at_ne();
    chk("t2_third_m0", gnt, 32'd1);
    chk("t2_third_adr", s_adr, 32'h14);
    adv();

    // m1 read while m0 requests mid-transfer
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
    at_ne();
    chk("t3_m0_rel", gnt, 32'd1);
    adv();
    at_ne();
    chk("t3_gap", gnt, 32'd0);
    adv();
    set_m0(1'b1, 1'b1, 1'b1, 32'h30, 32'h0BAD_0BAD);
    at_ne();
    chk("t3_gnt_m1", gnt, 32'd2);
    chk("t3_s_adr", s_adr, 32'h8);
    chk("t3_s_we", s_we, 32'd0);
    chk("t3_no_leak", s_dat_o, 32'h0);
    chk("t3_m0_stall", m0_ack, 32'd0);
    adv();
    s_ack = 1'b1;
    s_dat_i = 32'hCAFE_BABE;
    at_ne();
    chk("t3_m1_ack", m1_ack, 32'd1);
    chk("t3_m1_dat", m1_dat_i, 32'hCAFE_BABE);
    chk("t3_m0_ack0", m0_ack, 32'd0);
    chk("t3_m0_dat0", m0_dat_i, 32'h0);
    adv();
    s_ack = 1'b0;
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    at_ne();
    chk("t3_m0_dat_hold0", m0_dat_i, 32'h0);
    chk("t3_m1_rel_gnt", gnt, 32'd2);
    adv();
    at_ne();
    chk("t3_gap2", gnt, 32'd0);
    chk("t3_gap2_ack", m0_ack, 32'd0);
    adv();

    // m0 three-beat lock while m1 requests
    set_m1(1'b1, 1'b1, 1'b0, 32'h50, 32'h0);
    at_ne();
    chk("t4_gnt_m0", gnt, 32'd1);
    chk("t4_s_adr", s_adr, 32'h30);
    chk("t4_s_dat", s_dat_o, 32'h0BAD_0BAD);
    adv();
    set_m0(1'b1, 1'b1, 1'b1, 32'h0, 32'h1111_1111);
    s_ack = 1'b1;
    at_ne();
    chk("t4_b1_ack", m0_ack, 32'd1);
    chk("t4_b1_dat", s_dat_o, 32'h1111_1111);
    chk("t4_b1_m1", m1_ack, 32'd0);
    chk("t4_b1_gnt", gnt, 32'd1);
    adv();
    set_m0(1'b1, 1'b1, 1'b1, 32'h4, 32'h2222_2222);
    at_ne();
    chk("t4_b2_adr", s_adr, 32'h4);
    chk("t4_b2_ack", m0_ack, 32'd1);
    chk("t4_b2_gnt", gnt, 32'd1);
    adv();
    set_m0(1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
    s_dat_i = 32'h3333_3333;
    at_ne();
    chk("t4_b3_rdata", m0_dat_i, 32'h3333_3333);
    chk("t4_b3_we", s_we, 32'd0);
    chk("t4_b3_gnt", gnt, 32'd1);
    chk("t4_b3_m1dat", m1_dat_i, 32'h0);
    adv();
    s_ack = 1'b0;
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    at_ne();
    chk("t4_rel_gnt", gnt, 32'd1);
    adv();
    at_ne();
    chk("t4_gap", gnt, 32'd0);
    adv();
    at_ne();
    chk("t4_m1_turn", gnt, 32'd2);
    chk("t4_m1_adr", s_adr, 32'h50);
    adv();

    // watchdog timeout: slave never ACKs
    set_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    at_ne();
    chk("t5_m1_rel", gnt, 32'd2);
    adv();
    set_m0(1'b1, 1'b1, 1'b1, 32'h40, 32'hDEAD_0000);
    s_dat_i = 32'h5555_5555;
    at_ne();
    chk("t5_idle", gnt, 32'd0);
    adv();
    for (int i = 1; i <= 15; i++) begin
      at_ne();
      chk("t5_wait_to", timeout, 32'd0);
      chk("t5_wait_ack", m0_ack, 32'd0);
      chk("t5_wait_stb", s_stb, 32'd1);
      adv();
    end
    at_ne();
    chk("t5_to_pulse", timeout, 32'd1);
    chk("t5_to_ack", m0_ack, 32'd1);
    chk("t5_to_data", m0_dat_i, 32'h0);
    chk("t5_to_stb", s_stb, 32'd0);
    chk("t5_to_cyc", s_cyc, 32'd0);
    chk("t5_to_gnt", gnt, 32'd1);
    adv();
    set_m0(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    at_ne();
    chk("t5_pulse_end", timeout, 32'd0);
    chk("t5_after_ack", m0_ack, 32'd0);
    chk("t5_keep_gnt", gnt, 32'd1);
    chk("t5_keep_cyc", s_cyc, 32'd1);
    adv();

    // slave ACK in the 16th cycle wins over the watchdog
    set_m0(1'b1, 1'b1, 1'b0, 32'h44, 32'h0);
    for (int i = 1; i <= 15; i++) begin
      at_ne();
      chk("t6_wait_to", timeout, 32'd0);
      chk("t6_wait_ack", m0_ack, 32'd0);
      adv();
    end
    s_ack = 1'b1;
    s_dat_i = 32'h600D_F00D;
    at_ne();
    chk("t6_ack", m0_ack, 32'd1);
    chk("t6_data", m0_dat_i, 32'h600D_F00D);
    chk("t6_no_to", timeout, 32'd0);
    chk("t6_stb", s_stb, 32'd1);
    adv();
    s_ack = 1'b0;
    set_m0(1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
    at_ne();
    chk("t6_no_to2", timeout, 32'd0);
    adv();
    set_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    at_ne();
    adv();

    // asynchronous reset while m1 owns with STB high
    set_m1(1'b1, 1'b1, 1'b1, 32'h60, 32'h7777_7777);
    at_ne();
    chk("t7_idle", gnt, 32'd0);
    adv();
    at_ne();
    chk("t7_gnt_m1", gnt, 32'd2);
    chk("t7_stb_m1", s_stb, 32'd1);
    set_m0(1'b1, 1'b1, 1'b0, 32'h70, 32'h0);
    rst = 1'b0;
    #1;
    chk("t7_rst_gnt", gnt, 32'd0);
    chk("t7_rst_stb", s_stb, 32'd0);
    chk("t7_rst_cyc", s_cyc, 32'd0);
    chk("t7_rst_we", s_we, 32'd0);
    chk("t7_rst_m1ack", m1_ack, 32'd0);
    adv();
    at_ne();
    rst = 1'b1;
    adv();
    at_ne();
    chk("t7_m0_wins", gnt, 32'd1);
    chk("t7_m0_adr", s_adr, 32'h70);
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
